fifo_write_arbiter: RTL and testbench

Round-robin write-side arbiter that lets up to eight independent producers share one `fifo_sync` instance (non-fallthrough or fallthrough; the write side is identical). Each producer offers words over a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wen`/`wdata`, tagging each word with its source index. Back-pressure comes from the FIFO's `full`/`almost_full` flags, so no write is ever issued while the FIFO is full.

---
 rtl/fifo_write_arbiter_if.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between producers, the arbiter and a fifo_sync write port.
// Parameters must match the arbiter's pREQ / pDATA_WIDTH.

// Handshake: a producer word moves on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. A producer holds valid and data stable until that
// edge; the arbiter may raise or drop ready at any cycle. fifo_wen/fifo_wdata are
// registered and the FIFO captures on the edge where fifo_wen is high.
interface fifo_write_arbiter_if #(
  parameter int pREQ        = 4,
  parameter int pDATA_WIDTH = 8
);
  logic [pREQ-1:0]             req_valid;
  logic [pREQ*pDATA_WIDTH-1:0] req_data;
  logic [pREQ-1:0]             req_ready;
  logic                        fifo_wen;
  logic [pDATA_WIDTH+2:0]      fifo_wdata;
  logic                        fifo_full;
  logic                        fifo_almost_full;

  modport master (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wen, fifo_wdata
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_wen, fifo_wdata
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: up to eight producers share one FIFO write port in bounded bursts.
// Optional stall statistics are enabled by defining FIFO_ARB_STATS_EN.
module fifo_write_arbiter #(
  parameter int pREQ        = 4,
  parameter int pDATA_WIDTH = 8,
  parameter int pBURST      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_write_arbiter_if.slave bus,
  output logic [2:0]  grant_id,
`ifdef FIFO_ARB_STATS_EN
  input  logic        stall_clear,
  output logic [15:0] stall_count,
`endif
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state;
  logic [2:0]             last;
  logic [3:0]             burst_cnt;
  logic                   fifo_wen_q;
  logic [pDATA_WIDTH+2:0] fifo_wdata_q;

  // Requesters padded to eight slots so a 3-bit index is always in range.
  logic [7:0]             valid8;
  logic [pDATA_WIDTH-1:0] data8 [8];

  logic                   can_accept;
  logic                   gnt_valid;
  logic [pDATA_WIDTH-1:0] gnt_data;
  logic                   transfer;
  logic                   last_beat;
  logic                   any_valid;
  logic [2:0]             sel;

  // A write already on fifo_wen may take the last free slot, so almost_full blocks then.
  assign can_accept = !bus.fifo_full && !(bus.fifo_almost_full && fifo_wen_q);
  assign gnt_valid  = valid8[grant_id];
  assign gnt_data   = data8[grant_id];
  assign transfer   = (state == GRANT) && gnt_valid && can_accept;
  assign last_beat  = (burst_cnt == 4'(pBURST - 1));

  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < pREQ) begin : g_live
      assign valid8[g]        = bus.req_valid[g];
      assign data8[g]         = bus.req_data[g*pDATA_WIDTH +: pDATA_WIDTH];
      assign bus.req_ready[g] = (state == GRANT) && (grant_id == 3'(g)) && can_accept;
    end else begin : g_pad
      assign valid8[g] = 1'b0;
      assign data8[g]  = '0;
    end
  end

  // First valid requester after the last one served, wrapping modulo pREQ.
  always_comb begin
    logic [2:0] idx;
    idx       = '0;
    sel       = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= pREQ; k++) begin
      idx = 3'((int'(last) + k) % pREQ);
      if (!any_valid && valid8[idx]) begin
        any_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= 3'(pREQ - 1);
      burst_cnt    <= '0;
      grant_id     <= '0;
      fifo_wen_q   <= 1'b0;
      fifo_wdata_q <= '0;
    end else begin
      fifo_wen_q <= transfer;
      if (transfer) begin
        fifo_wdata_q <= {grant_id, gnt_data};
      end
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id  <= sel;
            last      <= sel;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // Back-pressure alone never releases the grant; only a finished burst or a dropped valid does.
          if (!gnt_valid) begin
            state <= IDLE;
          end else if (transfer) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_wen   = fifo_wen_q;
  assign bus.fifo_wdata = fifo_wdata_q;
  assign busy           = (state == GRANT);

`ifdef FIFO_ARB_STATS_EN
  // Counts cycles a granted, valid requester is held off by the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_clear) begin
      stall_count <= '0;
    end else if ((state == GRANT) && gnt_valid && !can_accept && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle vector table plus FIFO-full,
// reset-mid-burst and (with FIFO_ARB_STATS_EN) stall-counter sequences.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  grant_id;
  logic        busy;
  logic        use_model;
  logic        tbl_full;
  logic        tbl_af;
  logic        rd;
  int          cnt;
  int          wr_count;
  int          ovf_count;
  int          checks;
  int          failures;
`ifdef FIFO_ARB_STATS_EN
  logic        stall_clear;
  logic [15:0] stall_count;
`endif

  fifo_write_arbiter_if #(.pREQ(4), .pDATA_WIDTH(8)) bus ();

  fifo_write_arbiter #(.pREQ(4), .pDATA_WIDTH(8), .pBURST(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
`ifdef FIFO_ARB_STATS_EN
    .stall_clear (stall_clear),
    .stall_count (stall_count),
`endif
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-deep FIFO occupancy model; almost_full means one slot left.
  assign bus.fifo_full        = use_model ? (cnt == 32) : tbl_full;
  assign bus.fifo_almost_full = use_model ? (cnt == 31) : tbl_af;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 0;
      wr_count  <= 0;
      ovf_count <= 0;
    end else begin
      if (bus.fifo_wen && bus.fifo_full) ovf_count <= ovf_count + 1;
      if (bus.fifo_wen) wr_count <= wr_count + 1;
      cnt <= cnt + (bus.fifo_wen ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        af;
    logic [3:0]  ready;
    logic        wen;
    logic [10:0] wdata;
    logic [2:0]  gid;
    logic        busy;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    tbl_full       = 1'b0;
    tbl_af         = 1'b0;
    rd             = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stall_clear    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  localparam logic [31:0] DA = 32'h00A5_0000;
  localparam logic [31:0] DR = 32'hD3C2_B1A0;

  initial begin
    checks    = 0;
    failures  = 0;
    use_model = 1'b0;

    //            valid    data full af  ready    wen wdata   gid busy
    vecs[0]  = '{4'b0100, DA, 0, 0, 4'b0000, 0, 11'h000, 0, 0};
    vecs[1]  = '{4'b0100, DA, 0, 0, 4'b0100, 0, 11'h000, 2, 1};
    vecs[2]  = '{4'b0000, DA, 0, 0, 4'b0100, 1, 11'h2A5, 2, 1};
    vecs[3]  = '{4'b0000, DR, 0, 0, 4'b0000, 0, 11'h2A5, 2, 0};
    vecs[4]  = '{4'b1111, DR, 0, 0, 4'b0000, 0, 11'h2A5, 2, 0};
    vecs[5]  = '{4'b1111, DR, 0, 0, 4'b1000, 0, 11'h2A5, 3, 1};
    vecs[6]  = '{4'b1111, DR, 0, 0, 4'b1000, 1, 11'h3D3, 3, 1};
    vecs[7]  = '{4'b1111, DR, 0, 0, 4'b1000, 1, 11'h3D3, 3, 1};
    vecs[8]  = '{4'b1111, DR, 0, 0, 4'b1000, 1, 11'h3D3, 3, 1};
    vecs[9]  = '{4'b1111, DR, 0, 0, 4'b0000, 1, 11'h3D3, 3, 0};
    vecs[10] = '{4'b1111, DR, 0, 0, 4'b0001, 0, 11'h3D3, 0, 1};
    vecs[11] = '{4'b1111, DR, 1, 0, 4'b0000, 1, 11'h0A0, 0, 1};
    vecs[12] = '{4'b1111, DR, 1, 0, 4'b0000, 0, 11'h0A0, 0, 1};
    vecs[13] = '{4'b1111, DR, 0, 1, 4'b0001, 0, 11'h0A0, 0, 1};
    vecs[14] = '{4'b1111, DR, 0, 1, 4'b0000, 1, 11'h0A0, 0, 1};
    vecs[15] = '{4'b1111, DR, 0, 0, 4'b0001, 0, 11'h0A0, 0, 1};
    vecs[16] = '{4'b1111, DR, 0, 0, 4'b0001, 1, 11'h0A0, 0, 1};
    vecs[17] = '{4'b1010, DR, 0, 0, 4'b0000, 1, 11'h0A0, 0, 0};
    vecs[18] = '{4'b1010, DR, 0, 0, 4'b0010, 0, 11'h0A0, 1, 1};
    vecs[19] = '{4'b1010, DR, 0, 0, 4'b0010, 1, 11'h1B1, 1, 1};
    vecs[20] = '{4'b1000, DR, 0, 0, 4'b0010, 1, 11'h1B1, 1, 1};
    vecs[21] = '{4'b1010, DR, 0, 0, 4'b0000, 0, 11'h1B1, 1, 0};
    vecs[22] = '{4'b1010, DR, 0, 0, 4'b1000, 0, 11'h1B1, 3, 1};
    vecs[23] = '{4'b0010, DR, 0, 0, 4'b1000, 1, 11'h3D3, 3, 1};
    vecs[24] = '{4'b0010, DR, 0, 0, 4'b0000, 0, 11'h3D3, 3, 0};
    vecs[25] = '{4'b0000, DR, 0, 0, 4'b0010, 0, 11'h3D3, 1, 1};
    vecs[26] = '{4'b0000, DR, 0, 0, 4'b0000, 0, 11'h3D3, 1, 0};

    do_reset();
    #1;
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    check("reset_wen", 32'(bus.fifo_wen), 32'h0);
    check("reset_wdata", 32'(bus.fifo_wdata), 32'h0);
    check("reset_gid", 32'(grant_id), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // per-cycle vector table
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].data);
      tbl_full = vecs[i].full;
      tbl_af   = vecs[i].af;
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
      check($sformatf("v%0d_wen", i), 32'(bus.fifo_wen), 32'(vecs[i].wen));
      check($sformatf("v%0d_wdata", i), 32'(bus.fifo_wdata), 32'(vecs[i].wdata));
      check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].gid));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // FIFO fills: exactly 32 writes, then one more after a single read
    do_reset();
    use_model = 1'b1;
    drive(4'b0001, 32'h0000_00A0);
    repeat (150) @(negedge clk);
    #1;
    check("full_writes", 32'(wr_count), 32'd32);
    check("full_ready", 32'(bus.req_ready), 32'h0);
    check("full_wen", 32'(bus.fifo_wen), 32'h0);
    check("full_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("refill_writes", 32'(wr_count), 32'd33);
    check("refill_wdata", 32'(bus.fifo_wdata), 32'h0A0);
    check("overflow", 32'(ovf_count), 32'd0);

    // reset mid-burst while a write is in flight
    do_reset();
    drive(4'b0001, 32'h0000_005A);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        @(negedge clk);
        if (busy && bus.fifo_wen) hit = 1'b1;
      end
      check("midburst_reached", 32'(hit), 32'h1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wen", 32'(bus.fifo_wen), 32'h0);
    check("midrst_wdata", 32'(bus.fifo_wdata), 32'h0);
    check("midrst_gid", 32'(grant_id), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ready", 32'(bus.req_ready), 32'h0);
    use_model = 1'b0;

`ifdef FIFO_ARB_STATS_EN
    // stall counter: 10 held cycles, clear, then saturation
    do_reset();
    @(negedge clk);
    tbl_full = 1'b1;
    drive(4'b0001, 32'h0000_0011);
    repeat (11) @(negedge clk);
    #1;
    check("stall_10", 32'(stall_count), 32'd10);
    stall_clear = 1'b1;
    @(negedge clk);
    stall_clear = 1'b0;
    #1;
    check("stall_clear", 32'(stall_count), 32'd0);
    repeat (70000) @(negedge clk);
    #1;
    check("stall_sat", 32'(stall_count), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
